vending_ctrl_param: RTL and testbench
=====================================

// Module: vending_ctrl_param
// PURPOSE
//  Parametrised single-product vending controller. Accepts 5/10/25-unit coins, vends when credit
//  reaches PRICE, returns change serially as 5-unit pulses, supports cancel/refund, tracks stock
//  with sold-out lockout and refill. Sits between coin-acceptor pulses and dispenser/changer drivers.
// PARAMETERS
//  PRICE       15   product price in units; multiple of 5, 5..MAX_CREDIT
//  MAX_CREDIT  30   highest credit accepted; multiple of 5; coin pushing credit above it is rejected
//  CREDIT_W    6    credit register width; 2**CREDIT_W > MAX_CREDIT
//  STOCK_W     4    stock counter width
//  STOCK_INIT  10   stock after reset/refill; < 2**STOCK_W
// PORTS
//  clk       in   1         clock, all state on rising edge
//  rst       in   1         reset, asynchronous, active-high
//  c5        in   1         5-unit coin, 1-cycle pulse
//  c10       in   1         10-unit coin, 1-cycle pulse
//  c25       in   1         25-unit coin, 1-cycle pulse
//  cancel    in   1         refund request, 1-cycle pulse
//  refill    in   1         reload stock to STOCK_INIT
//  p_out     out  1         product dispense, 1-cycle pulse per vend
//  c_out     out  1         change out, 1-cycle pulse per 5 units returned
//  coin_rej  out  1         coin rejected, 1-cycle pulse
//  busy      out  1         high in VEND or CHANGE
//  sold_out  out  1         stock == 0
//  credit    out  CREDIT_W  current credit in units
//  stock     out  STOCK_W   remaining products
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, credit 0, stock STOCK_INIT; p_out, c_out, coin_rej, busy 0;
//    sold_out 0. Reset mid-VEND/CHANGE discards credit; no further pulses.
//  - All outputs registered. States: IDLE (credit 0), COLLECT, VEND, CHANGE.
//  - Coin sampling (IDLE/COLLECT): exactly one of c5/c10/c25 high -> accept if !sold_out and
//    credit+value <= MAX_CREDIT (sum computed CREDIT_W+1 bits); credit updated at same edge.
//    Otherwise coin_rej=1 for the following cycle, credit unchanged. Two or more coins same cycle -> rejected.
//  - Accept making credit >= PRICE: same edge enters VEND, p_out and busy rise (p_out high 1 cycle).
//    Accept with credit < PRICE: go/stay COLLECT.
//  - VEND (1 cycle): at exit edge credit -= PRICE, stock -= 1; remainder > 0 -> CHANGE, else IDLE.
//  - CHANGE: c_out high every cycle while credit > 0; credit -= 5 per edge; IDLE after last pulse.
//    Pulse count = remainder/5, back to back.
//  - cancel in COLLECT -> CHANGE (full refund, no p_out). cancel in IDLE/VEND/CHANGE ignored.
//    cancel and coin same cycle in COLLECT: cancel wins, coin rejected (coin_rej).
//  - Coins in VEND/CHANGE -> coin_rej, not credited.
//  - refill: stock <= STOCK_INIT next edge in any state; overrides simultaneous VEND decrement.
//  - sold_out = (stock == 0), registered with stock; credit already held when stock hits 0 remains
//    refundable by cancel.
// TESTING (defaults)
//  c10, then c5 -> p_out 1 cycle on c5 edge, no c_out, credit 15->0, stock 10->9, busy 1 cycle
//  c25 -> p_out 1 cycle, then 2 consecutive c_out pulses, credit 0, stock 9
//  c10, cancel -> 2 c_out pulses, no p_out, stock unchanged, credit 0
//  c10, c25 (35 > 30) -> coin_rej 1 cycle, credit stays 10; c5 -> vend, no change; c5+c10 same cycle -> coin_rej
//  vend to stock 0 -> sold_out=1; c5 -> coin_rej; refill -> stock 10, sold_out 0; refill during VEND -> stock 10
//  c25, rst asserted during first c_out -> all outputs 0 immediately, credit 0, stock 10, state IDLE

Source files
------------

// File: rtl/vending_ctrl_param.sv
// Single-product vending controller: coin credit, vend, serial 5-unit change,
// cancel/refund, stock tracking with sold-out lockout and refill.
module vending_ctrl_param #(
  parameter int PRICE      = 15,
  parameter int MAX_CREDIT = 30,
  parameter int CREDIT_W   = 6,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c5,
  input  logic                c10,
  input  logic                c25,
  input  logic                cancel,
  input  logic                refill,
  output logic                p_out,
  output logic                c_out,
  output logic                coin_rej,
  output logic                busy,
  output logic                sold_out,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [STOCK_W-1:0]  r_stock, w_stock_nxt;
  logic                r_p_out, r_c_out, r_coin_rej, r_busy, r_sold_out;
  logic                w_p_nxt, w_rej_nxt;
  logic                w_any_coin, w_one_coin, w_accept;
  logic [CREDIT_W:0]   w_coin_val, w_sum;

  assign w_any_coin = c5 | c10 | c25;
  assign w_one_coin = $onehot({c5, c10, c25});
  // Value only meaningful when exactly one coin line is high.
  assign w_coin_val = c25 ? (CREDIT_W+1)'(25) : (c10 ? (CREDIT_W+1)'(10) : (CREDIT_W+1)'(5));
  // One extra bit so an overflowing sum is still compared correctly.
  assign w_sum      = {1'b0, r_credit} + w_coin_val;
  assign w_accept   = w_one_coin && !r_sold_out && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  // Next-state, next-credit/stock and next-output decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_stock_nxt  = r_stock;
    w_p_nxt      = 1'b0;
    w_rej_nxt    = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (r_state == S_COLLECT && cancel) begin
          // Full refund; a coin arriving alongside cancel is bounced.
          w_state_nxt = S_CHANGE;
          w_rej_nxt   = w_any_coin;
        end else if (w_any_coin) begin
          if (w_accept) begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
            if (w_sum >= (CREDIT_W+1)'(PRICE)) begin
              w_state_nxt = S_VEND;
              w_p_nxt     = 1'b1;
            end else begin
              w_state_nxt = S_COLLECT;
            end
          end else begin
            w_rej_nxt = 1'b1;
          end
        end
      end
      S_VEND: begin
        w_rej_nxt    = w_any_coin;
        w_credit_nxt = r_credit - CREDIT_W'(PRICE);
        w_stock_nxt  = r_stock - STOCK_W'(1);
        w_state_nxt  = (w_credit_nxt != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        // Pulse shown this cycle pays out 5 units at the closing edge.
        w_rej_nxt    = w_any_coin;
        w_credit_nxt = r_credit - CREDIT_W'(5);
        w_state_nxt  = (w_credit_nxt != '0) ? S_CHANGE : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (refill) w_stock_nxt = STOCK_W'(STOCK_INIT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_stock    <= STOCK_W'(STOCK_INIT);
      r_p_out    <= 1'b0;
      r_c_out    <= 1'b0;
      r_coin_rej <= 1'b0;
      r_busy     <= 1'b0;
      r_sold_out <= (STOCK_INIT == 0);
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_stock    <= w_stock_nxt;
      r_p_out    <= w_p_nxt;
      r_c_out    <= (w_state_nxt == S_CHANGE);
      r_coin_rej <= w_rej_nxt;
      r_busy     <= (w_state_nxt == S_VEND) || (w_state_nxt == S_CHANGE);
      r_sold_out <= (w_stock_nxt == '0);
    end
  end

  assign p_out    = r_p_out;
  assign c_out    = r_c_out;
  assign coin_rej = r_coin_rej;
  assign busy     = r_busy;
  assign sold_out = r_sold_out;
  assign credit   = r_credit;
  assign stock    = r_stock;

endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: a transaction-level model expands each vend or
// refund into the list of output frames it must produce; outputs are compared
// every cycle, plus directed literal checks on the default-parameter scenarios.
module tb_vending_ctrl_param;
  localparam int PRICE = 15, MAX_CREDIT = 30, CREDIT_W = 6, STOCK_W = 4, STOCK_INIT = 10;

  logic clk = 1'b0;
  logic rst;
  logic c5 = 0, c10 = 0, c25 = 0, cancel = 0, refill = 0;
  logic p_out, c_out, coin_rej, busy, sold_out;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;

  vending_ctrl_param #(.PRICE(PRICE), .MAX_CREDIT(MAX_CREDIT), .CREDIT_W(CREDIT_W),
                       .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)) dut (
    .clk(clk), .rst(rst), .c5(c5), .c10(c10), .c25(c25), .cancel(cancel), .refill(refill),
    .p_out(p_out), .c_out(c_out), .coin_rej(coin_rej), .busy(busy), .sold_out(sold_out),
    .credit(credit), .stock(stock));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cnt_p = 0, cnt_c = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: a busy transaction is a queue of output frames
  typedef struct { bit p; bit c; int cr; } frame_t;
  frame_t q[$];
  int m_credit = 0, m_stock = STOCK_INIT;
  int e_p = 0, e_c = 0, e_rej = 0, e_busy = 0, e_sold = 0, e_credit = 0, e_stock = STOCK_INIT;

  always @(posedge clk or posedge rst) begin
    int n, val;
    frame_t f;
    if (rst) begin
      m_credit = 0; m_stock = STOCK_INIT; q.delete(); e_rej = 0;
    end else begin
      n = int'(c5) + int'(c10) + int'(c25);
      e_rej = 0;
      if (q.size() > 0) begin
        f = q.pop_front();
        if (f.p) m_stock = m_stock - 1;
        e_rej = (n > 0) ? 1 : 0;
      end else if (m_credit > 0 && cancel) begin
        e_rej = (n > 0) ? 1 : 0;
        for (int v = m_credit; v > 0; v -= 5) q.push_back('{1'b0, 1'b1, v});
        m_credit = 0;
      end else if (n > 0) begin
        val = c25 ? 25 : (c10 ? 10 : 5);
        if (n == 1 && m_stock > 0 && m_credit + val <= MAX_CREDIT) begin
          m_credit = m_credit + val;
          if (m_credit >= PRICE) begin
            q.push_back('{1'b1, 1'b0, m_credit});
            for (int v = m_credit - PRICE; v > 0; v -= 5) q.push_back('{1'b0, 1'b1, v});
            m_credit = 0;
          end
        end else e_rej = 1;
      end
      if (refill) m_stock = STOCK_INIT;
    end
    if (q.size() > 0) begin
      e_p = q[0].p; e_c = q[0].c; e_credit = q[0].cr; e_busy = 1;
    end else begin
      e_p = 0; e_c = 0; e_credit = m_credit; e_busy = 0;
    end
    e_stock = m_stock;
    e_sold  = (m_stock == 0) ? 1 : 0;
  end

  // ---------------- per-cycle compare against the model
  always @(negedge clk) begin
    check("p_out",    32'(p_out),    32'(e_p));
    check("c_out",    32'(c_out),    32'(e_c));
    check("coin_rej", 32'(coin_rej), 32'(e_rej));
    check("busy",     32'(busy),     32'(e_busy));
    check("sold_out", 32'(sold_out), 32'(e_sold));
    check("credit",   32'(credit),   32'(e_credit));
    check("stock",    32'(stock),    32'(e_stock));
    cnt_p += int'(p_out);
    cnt_c += int'(c_out);
  end

  // One input cycle; returns just after the negedge following the sampling edge.
  task automatic step(input bit a5, input bit a10, input bit a25, input bit acn, input bit arf);
    c5 = a5; c10 = a10; c25 = a25; cancel = acn; refill = arf;
    @(negedge clk); #1;
    c5 = 0; c10 = 0; c25 = 0; cancel = 0; refill = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  int p0, cc0;

  initial begin
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst_credit", 32'(credit), 0);
    check("rst_stock",  32'(stock),  10);
    check("rst_busy",   32'(busy),   0);
    check("rst_sold",   32'(sold_out), 0);
    rst = 1'b0;
    idle(1);

    // c10 then c5: exact vend, no change
    p0 = cnt_p; cc0 = cnt_c;
    step(0,1,0,0,0); check("s1_credit10", 32'(credit), 10);
    step(1,0,0,0,0); check("s1_pout", 32'(p_out), 1); check("s1_busy", 32'(busy), 1);
    check("s1_credit15", 32'(credit), 15);
    idle(2);
    check("s1_credit0", 32'(credit), 0); check("s1_stock", 32'(stock), 9);
    check("s1_npulse", 32'(cnt_p - p0), 1); check("s1_nchange", 32'(cnt_c - cc0), 0);

    // c25: vend plus two change pulses
    p0 = cnt_p; cc0 = cnt_c;
    step(0,0,1,0,0); check("s2_pout", 32'(p_out), 1);
    idle(1); check("s2_cout1", 32'(c_out), 1); check("s2_cred10", 32'(credit), 10);
    idle(1); check("s2_cout2", 32'(c_out), 1); check("s2_cred5", 32'(credit), 5);
    idle(2);
    check("s2_nchange", 32'(cnt_c - cc0), 2); check("s2_stock", 32'(stock), 8);
    check("s2_credit0", 32'(credit), 0);

    // c10 then cancel: full refund
    p0 = cnt_p; cc0 = cnt_c;
    step(0,1,0,0,0); step(0,0,0,1,0);
    check("s3_cout", 32'(c_out), 1); check("s3_busy", 32'(busy), 1);
    idle(3);
    check("s3_nchange", 32'(cnt_c - cc0), 2); check("s3_npout", 32'(cnt_p - p0), 0);
    check("s3_stock", 32'(stock), 8); check("s3_credit", 32'(credit), 0);

    // overflow reject, then vend; double coin; cancel beats coin; coin during VEND
    step(0,1,0,0,0); step(0,0,1,0,0);
    check("s4_rej", 32'(coin_rej), 1); check("s4_cred", 32'(credit), 10);
    idle(1); check("s4_rej_clr", 32'(coin_rej), 0);
    step(1,0,0,0,0); check("s4_pout", 32'(p_out), 1);
    idle(2); check("s4_stock", 32'(stock), 7);
    step(1,1,0,0,0); check("s4_dbl_rej", 32'(coin_rej), 1); check("s4_dbl_cred", 32'(credit), 0);
    step(1,0,0,0,0); step(0,1,0,1,0);
    check("s4_cx_rej", 32'(coin_rej), 1); check("s4_cx_cout", 32'(c_out), 1);
    check("s4_cx_cred", 32'(credit), 5);
    idle(2);
    step(0,1,0,0,0); step(1,0,0,0,0); step(0,0,1,0,0);
    check("s4_vend_rej", 32'(coin_rej), 1); check("s4_vend_cred", 32'(credit), 0);
    check("s4_vend_stock", 32'(stock), 6);
    idle(1);

    // drain to sold out, lockout, refill, refill during VEND
    for (int k = 0; k < 6; k++) begin step(1,0,0,0,0); step(0,1,0,0,0); idle(1); end
    check("s5_stock0", 32'(stock), 0); check("s5_sold", 32'(sold_out), 1);
    step(1,0,0,0,0); check("s5_lock_rej", 32'(coin_rej), 1); check("s5_lock_cred", 32'(credit), 0);
    step(0,0,0,0,1); check("s5_refill", 32'(stock), 10); check("s5_sold0", 32'(sold_out), 0);
    step(0,1,0,0,0); step(1,0,0,0,0); step(0,0,0,0,1);
    check("s5_vend_refill", 32'(stock), 10);
    idle(1);

    // reset asserted during the first change pulse
    step(0,0,1,0,0); idle(1);
    check("s6_cout_pre", 32'(c_out), 1);
    cc0 = cnt_c;
    rst = 1'b1; #1;
    check("s6_cout", 32'(c_out), 0); check("s6_busy", 32'(busy), 0);
    check("s6_pout", 32'(p_out), 0); check("s6_credit", 32'(credit), 0);
    check("s6_stock", 32'(stock), 10);
    @(negedge clk); #1; rst = 1'b0;
    idle(3);
    check("s6_no_more", 32'(cnt_c - cc0), 0);
    step(1,0,0,0,0); check("s6_idle_accept", 32'(credit), 5);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
